// File: rtl/wb_config_loader.sv
// wb_config_loader: streams 32-bit words into Wishbone single writes per config region; WB_LOADER_TIMEOUT_EN adds an ack watchdog
module wb_config_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          REGION_SHIFT   = 24,
  parameter int          NUM_REGIONS    = 2,
  parameter int          REGION_W       = 1,
  parameter int          CNT_W          = 16,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start_i,
  input  logic [REGION_W-1:0] region_i,
  input  logic [CNT_W-1:0]    num_words_i,
  input  logic [31:0]         s_data_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [3:0]          wbm_sel_o,
  output logic [31:0]         wbm_addr_o,
  output logic [31:0]         wbm_data_o,
  input  logic                wbm_ack_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [CNT_W-1:0]    words_done_o
);
  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [REGION_W-1:0] region_q, region_d;
  logic [CNT_W-1:0] count_q, count_d, words_q, words_d, words_inc;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d, cyc_q, cyc_d;
  logic [3:0] sel_q, sel_d;
  logic timeout;
`ifdef WB_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  assign timeout = tmo_q == TW'(TIMEOUT_CYCLES - 1);
  assign tmo_d = (state_q == WRITE && !wbm_ack_i) ? tmo_q + TW'(1) : '0;
  always_ff @(posedge wb_clk_i) tmo_q <= wb_rst_i ? '0 : tmo_d;
`else
  logic unused_tmo;
  assign timeout = 1'b0;
  assign unused_tmo = |TIMEOUT_CYCLES;
`endif
  always_comb begin
    state_d = state_q;
    region_d = region_q;
    count_d = count_q;
    words_d = words_q;
    addr_d = addr_q;
    data_d = data_q;
    err_d = err_q;
    words_inc = words_q + CNT_W'(1);
    case (state_q)
      IDLE: if (start_i) begin
        if (32'(region_i) >= 32'(NUM_REGIONS)) err_d = 1'b1;
        else begin
          err_d = 1'b0;
          region_d = region_i;
          count_d = num_words_i;
          words_d = '0;
          state_d = (num_words_i == '0) ? DONE : FETCH;
        end
      end
      FETCH: if (s_valid_i && ready_q) begin
        data_d = s_data_i;
        addr_d = BASE_ADDR + (32'(region_q) << REGION_SHIFT) + (32'(words_q) << 2);
        state_d = WRITE;
      end
      WRITE: if (wbm_ack_i) begin
        words_d = words_inc;
        state_d = (words_inc == count_q) ? DONE : FETCH;
      end else if (timeout) begin
        err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = state_d == FETCH;
    cyc_d = state_d == WRITE;
    busy_d = state_d == FETCH || state_d == WRITE;
    sel_d = cyc_d ? 4'hF : 4'h0;
    done_d = state_q == DONE;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      region_q <= '0;
      count_q <= '0;
      words_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      cyc_q <= 1'b0;
      sel_q <= '0;
    end else begin
      state_q <= state_d;
      region_q <= region_d;
      count_q <= count_d;
      words_q <= words_d;
      addr_q <= addr_d;
      data_q <= data_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      cyc_q <= cyc_d;
      sel_q <= sel_d;
    end
  end
  assign s_ready_o = ready_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o = cyc_q;
  assign wbm_sel_o = sel_q;
  assign wbm_addr_o = addr_q;
  assign wbm_data_o = data_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o = err_q;
  assign words_done_o = words_q;
endmodule

// File: tb/tb_wb_config_loader.sv
// tb_wb_config_loader: directed bench for wb_config_loader with a Wishbone responder and bus monitor
module tb_wb_config_loader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, svalid = 1'b0, ack = 1'b0;
  logic [1:0] region = '0;
  logic [15:0] num = '0;
  logic [31:0] sdata = '0;
  logic s_ready_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o, done_o, err_o;
  logic [3:0] wbm_sel_o;
  logic [31:0] wbm_addr_o, wbm_data_o;
  logic [15:0] words_done_o;
  int checks = 0, failures = 0;
  logic [31:0] addr_q[$], data_q[$];
  int len_q[$];
  int strobes = 0, stab_err = 0, done_cnt = 0, done_long = 0, cur_len = 0;
  int ack_dly = 0, stall_from = 1000000, wcnt = 0;
  logic spur = 1'b0, prev_done = 1'b0;
  logic [31:0] cur_addr = '0, cur_data = '0;

  always #5 clk = ~clk;

  wb_config_loader #(.REGION_W(2), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .region_i(region), .num_words_i(num),
    .s_data_i(sdata), .s_valid_i(svalid), .s_ready_o(s_ready_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_addr_o(wbm_addr_o), .wbm_data_o(wbm_data_o), .wbm_ack_i(ack),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_done_o(words_done_o)
  );

  always @(negedge clk) begin
    if (wbm_cyc_o) begin
      if (cur_len == 0) begin
        strobes++;
        addr_q.push_back(wbm_addr_o);
        data_q.push_back(wbm_data_o);
        cur_addr = wbm_addr_o;
        cur_data = wbm_data_o;
      end else if (wbm_addr_o !== cur_addr || wbm_data_o !== cur_data) stab_err++;
      if (wbm_stb_o !== 1'b1 || wbm_we_o !== 1'b1 || wbm_sel_o !== 4'hF) stab_err++;
      cur_len++;
      ack = (wcnt >= ack_dly) && (strobes < stall_from);
      wcnt++;
    end else begin
      if (cur_len != 0) len_q.push_back(cur_len);
      if (wbm_stb_o !== 1'b0) stab_err++;
      cur_len = 0;
      wcnt = 0;
      ack = spur;
    end
    if (done_o) begin
      done_cnt++;
      if (prev_done) done_long++;
    end
    prev_done = done_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_mon();
    @(posedge clk); #1;
    addr_q.delete(); data_q.delete(); len_q.delete();
    strobes = 0; stab_err = 0; done_cnt = 0; done_long = 0;
    @(negedge clk);
  endtask

  task automatic do_start(input logic [1:0] r, input logic [15:0] n);
    region = r; num = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] w, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    sdata = w; svalid = 1'b1;
    while (!s_ready_o && n < 200) begin @(negedge clk); n++; end
    checks++; if (s_ready_o !== 1'b1) begin failures++; $display("FAIL feed_handshake: s_ready_o=%b required 1", s_ready_o); end
    @(negedge clk);
    svalid = 1'b0; sdata = 32'hDEAD_BEEF;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 300) begin @(negedge clk); n++; end
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL wait_done: done_o=%b required 1", done_o); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_addr_o, wbm_data_o, s_ready_o, busy_o, done_o, err_o, words_done_o} !== '0) begin
      failures++; $display("FAIL reset_outputs: cyc=%b busy=%b ready=%b addr=%h words=%0d required all 0", wbm_cyc_o, busy_o, s_ready_o, wbm_addr_o, words_done_o); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({wbm_cyc_o, s_ready_o, busy_o, done_o, err_o} !== 5'b0) begin
      failures++; $display("FAIL idle_after_reset: cyc=%b ready=%b busy=%b done=%b err=%b required 0", wbm_cyc_o, s_ready_o, busy_o, done_o, err_o); end
  endtask

  task automatic test_basic();
    clear_mon(); ack_dly = 0;
    do_start(2'd1, 16'd3);
    checks++; if ({busy_o, s_ready_o, wbm_cyc_o} !== 3'b110) begin failures++; $display("FAIL basic_fetch: busy,ready,cyc=%b required 110", {busy_o, s_ready_o, wbm_cyc_o}); end
    for (int i = 0; i < 3; i++) feed(32'hA5A5_0001 + i, 0);
    wait_done();
    checks++; if (strobes != 3) begin failures++; $display("FAIL basic_writes: got %0d required 3", strobes); end
    for (int i = 0; i < 3; i++) begin
      checks++; if ((i < addr_q.size() ? addr_q[i] : 32'hx) !== 32'h3100_0000 + 32'(4 * i)) begin failures++; $display("FAIL basic_addr%0d: got %h required %h", i, i < addr_q.size() ? addr_q[i] : 32'hx, 32'h3100_0000 + 32'(4 * i)); end
      checks++; if ((i < data_q.size() ? data_q[i] : 32'hx) !== 32'hA5A5_0001 + 32'(i)) begin failures++; $display("FAIL basic_data%0d: got %h required %h", i, i < data_q.size() ? data_q[i] : 32'hx, 32'hA5A5_0001 + 32'(i)); end
      checks++; if ((i < len_q.size() ? len_q[i] : -1) != 1) begin failures++; $display("FAIL basic_len%0d: got %0d required 1", i, i < len_q.size() ? len_q[i] : -1); end
    end
    checks++; if (stab_err != 0) begin failures++; $display("FAIL basic_bus_stable: got %0d violations required 0", stab_err); end
    checks++; if (done_cnt != 1 || done_long != 0) begin failures++; $display("FAIL basic_done_pulse: count=%0d long=%0d required 1/0", done_cnt, done_long); end
    checks++; if (words_done_o !== 16'd3) begin failures++; $display("FAIL basic_words_done: got %0d required 3", words_done_o); end
    checks++; if ({busy_o, err_o} !== 2'b00) begin failures++; $display("FAIL basic_status: busy,err=%b required 00", {busy_o, err_o}); end
  endtask

  task automatic test_wait_gap();
    clear_mon(); ack_dly = 5;
    do_start(2'd0, 16'd2);
    feed(32'h1111_0000, 4);
    feed(32'h2222_0001, 4);
    wait_done();
    checks++; if (strobes != 2) begin failures++; $display("FAIL gap_writes: got %0d required 2", strobes); end
    checks++; if ((addr_q.size() > 1 ? addr_q[1] : 32'hx) !== 32'h3000_0004) begin failures++; $display("FAIL gap_addr1: got %h required 30000004", addr_q.size() > 1 ? addr_q[1] : 32'hx); end
    checks++; if ((data_q.size() > 1 ? data_q[1] : 32'hx) !== 32'h2222_0001) begin failures++; $display("FAIL gap_data1: got %h required 22220001", data_q.size() > 1 ? data_q[1] : 32'hx); end
    checks++; if ((len_q.size() > 1 ? len_q[0] + len_q[1] : -1) != 12) begin failures++; $display("FAIL gap_len: got %0d required 12", len_q.size() > 1 ? len_q[0] + len_q[1] : -1); end
    checks++; if (stab_err != 0) begin failures++; $display("FAIL gap_bus_stable: got %0d violations required 0", stab_err); end
    checks++; if (words_done_o !== 16'd2 || done_cnt != 1) begin failures++; $display("FAIL gap_completion: words=%0d done=%0d required 2/1", words_done_o, done_cnt); end
    ack_dly = 0;
  endtask

  task automatic test_zero_words();
    clear_mon();
    do_start(2'd1, 16'd0);
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL zero_done_early: got %b required 0", done_o); end
    @(negedge clk);
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL zero_done_pulse: got %b required 1", done_o); end
    @(negedge clk);
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL zero_done_width: got %b required 0", done_o); end
    repeat (3) @(negedge clk);
    checks++; if (strobes != 0 || words_done_o !== 16'd0) begin failures++; $display("FAIL zero_no_bus: writes=%0d words=%0d required 0/0", strobes, words_done_o); end
  endtask

  task automatic test_bad_region();
    clear_mon();
    do_start(2'd2, 16'd3);
    svalid = 1'b1; sdata = 32'h0BAD_0BAD;
    repeat (10) @(negedge clk);
    svalid = 1'b0;
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL bad_region_err: got %b required 1", err_o); end
    checks++; if (strobes != 0 || done_cnt != 0 || busy_o !== 1'b0) begin failures++; $display("FAIL bad_region_idle: writes=%0d done=%0d busy=%b required 0", strobes, done_cnt, busy_o); end
  endtask

  task automatic test_reset_mid();
    clear_mon(); ack_dly = 2;
    do_start(2'd0, 16'd4);
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL start_clears_err: got %b required 0", err_o); end
    feed(32'h5555_0000, 0);
    feed(32'h5555_0001, 0);
    checks++; if (wbm_cyc_o !== 1'b1 || wbm_addr_o !== 32'h3000_0004) begin failures++; $display("FAIL rst_second_strobe: cyc=%b addr=%h required 1/30000004", wbm_cyc_o, wbm_addr_o); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({wbm_cyc_o, wbm_stb_o, busy_o, s_ready_o, err_o, words_done_o} !== '0) begin failures++; $display("FAIL rst_mid_clear: cyc=%b stb=%b busy=%b words=%0d required 0", wbm_cyc_o, wbm_stb_o, busy_o, words_done_o); end
    rst = 1'b0; ack_dly = 0;
    clear_mon();
    do_start(2'd0, 16'd1);
    feed(32'hC0DE_0001, 0);
    wait_done();
    checks++; if ((addr_q.size() > 0 ? addr_q[0] : 32'hx) !== 32'h3000_0000 || strobes != 1) begin failures++; $display("FAIL rst_restart_addr: got %h writes=%0d required 30000000/1", addr_q.size() > 0 ? addr_q[0] : 32'hx, strobes); end
    checks++; if ((data_q.size() > 0 ? data_q[0] : 32'hx) !== 32'hC0DE_0001) begin failures++; $display("FAIL rst_restart_data: got %h required c0de0001", data_q.size() > 0 ? data_q[0] : 32'hx); end
  endtask

  task automatic test_spurious();
    clear_mon(); spur = 1'b1; ack_dly = 1;
    repeat (3) @(negedge clk);
    region = 2'd1; num = 16'd3; start = 1'b1;
    @(negedge clk);
    feed(32'h7777_0000, 0);
    region = 2'd0; num = 16'd9;
    feed(32'h7777_0001, 0);
    start = 1'b0;
    feed(32'h7777_0002, 0);
    wait_done();
    spur = 1'b0; ack_dly = 0;
    checks++; if (strobes != 3 || words_done_o !== 16'd3) begin failures++; $display("FAIL spur_count: writes=%0d words=%0d required 3/3", strobes, words_done_o); end
    checks++; if ((addr_q.size() > 2 ? addr_q[2] : 32'hx) !== 32'h3100_0008) begin failures++; $display("FAIL spur_addr2: got %h required 31000008", addr_q.size() > 2 ? addr_q[2] : 32'hx); end
    checks++; if ((len_q.size() > 2 ? len_q[0] + len_q[1] + len_q[2] : -1) != 6) begin failures++; $display("FAIL spur_len: got %0d required 6", len_q.size() > 2 ? len_q[0] + len_q[1] + len_q[2] : -1); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL spur_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_timeout();
    clear_mon(); ack_dly = 0; stall_from = 2;
    do_start(2'd0, 16'd3);
    feed(32'h9999_0000, 0);
    feed(32'h9999_0001, 0);
    repeat (40) @(negedge clk);
`ifdef WB_LOADER_TIMEOUT_EN
    checks++; if ((len_q.size() > 1 ? len_q[1] : -1) != 8) begin failures++; $display("FAIL tmo_strobe_len: got %0d required 8", len_q.size() > 1 ? len_q[1] : -1); end
    checks++; if ({err_o, busy_o, wbm_cyc_o} !== 3'b100) begin failures++; $display("FAIL tmo_status: err,busy,cyc=%b required 100", {err_o, busy_o, wbm_cyc_o}); end
`else
    checks++; if ({wbm_cyc_o, wbm_stb_o, busy_o, err_o} !== 4'b1110) begin failures++; $display("FAIL stall_held: cyc,stb,busy,err=%b required 1110", {wbm_cyc_o, wbm_stb_o, busy_o, err_o}); end
    checks++; if (wbm_addr_o !== 32'h3000_0004 || stab_err != 0) begin failures++; $display("FAIL stall_stable: addr=%h violations=%0d required 30000004/0", wbm_addr_o, stab_err); end
`endif
    checks++; if (words_done_o !== 16'd1 || done_cnt != 0) begin failures++; $display("FAIL stall_words: words=%0d done=%0d required 1/0", words_done_o, done_cnt); end
    stall_from = 1000000;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_gap();
    test_zero_words();
    test_bad_region();
    test_reset_mid();
    test_spurious();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
